// File: rtl/rv32i_mmio_memory_if.sv
// Single-port memory bus between the multicycle RV32I core and its memory responder.
// The core is the master: it drives the address, the write data and the write strobe, and it takes back the read data.
interface rv32i_mmio_memory_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ena;
  logic [31:0] mem_rd_data;

  modport master (
    output mem_addr,
    output mem_wr_data,
    output mem_wr_ena,
    input  mem_rd_data
  );

  modport slave (
    input  mem_addr,
    input  mem_wr_data,
    input  mem_wr_ena,
    output mem_rd_data
  );
endinterface

// File: rtl/rv32i_mmio_memory.sv
// Word RAM plus an MMIO page (LED, 64-bit cycle counter, sticky bus fault) for the RV32I core.
// Read data is registered with 1-cycle latency and is read-before-write; ena=0 freezes all state.
module rv32i_mmio_memory #(
  parameter int RAM_WORDS = 256,
  parameter     INIT_FILE = "",
  parameter int LED_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  rv32i_mmio_memory_if.slave   bus,
  output logic [LED_WIDTH-1:0] leds,
  output logic                 bus_fault
);
  localparam int AW = $clog2(RAM_WORDS);

  // These are word indices, so they are the byte addresses 0xF000_0000..0xF000_000C shifted right by 2.
  localparam logic [29:0] LED_W   = 30'h3C00_0000;
  localparam logic [29:0] LO_W    = 30'h3C00_0001;
  localparam logic [29:0] HI_W    = 30'h3C00_0002;
  localparam logic [29:0] FAULT_W = 30'h3C00_0003;

  logic [31:0]   ram [RAM_WORDS];
  logic [31:0]   rd_q;
  logic [63:0]   cycle_cnt;
  logic [31:0]   hi_latch;
  logic          fault;

  logic [29:0]   word;
  logic [AW-1:0] ram_idx;
  logic          is_ram, is_led, is_lo, is_hi, is_fault, unmapped;
  logic          we, fault_set, fault_clr;
  logic [31:0]   rd_next;

  assign word     = bus.mem_addr[31:2];
  assign ram_idx  = bus.mem_addr[AW+1:2];
  assign is_ram   = (bus.mem_addr[31:AW+2] == '0);
  assign is_led   = (word == LED_W);
  assign is_lo    = (word == LO_W);
  assign is_hi    = (word == HI_W);
  assign is_fault = (word == FAULT_W);
  assign unmapped = !(is_ram || is_led || is_lo || is_hi || is_fault);
  assign we       = bus.mem_wr_ena;

  // A misaligned access still completes on the truncated word, and it also raises the fault flag.
  assign fault_set = (bus.mem_addr[1:0] != 2'b00) || unmapped || (we && (is_lo || is_hi));
  assign fault_clr = we && is_fault && bus.mem_wr_data[0];

  always_comb begin
    rd_next = '0;
    if (is_ram)        rd_next = ram[ram_idx];
    else if (is_led)   rd_next[LED_WIDTH-1:0] = leds;
    else if (is_lo)    rd_next = cycle_cnt[31:0];
    else if (is_hi)    rd_next = hi_latch;
    else if (is_fault) rd_next = {31'b0, fault};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q      <= '0;
      leds      <= '0;
      cycle_cnt <= '0;
      hi_latch  <= '0;
      fault     <= 1'b0;
    end else if (ena) begin
      rd_q      <= rd_next;
      cycle_cnt <= cycle_cnt + 64'd1;
      // Capture the high half of the same pre-increment value that the low-word read returns.
      if (is_lo)
        hi_latch <= cycle_cnt[63:32];
      if (we && is_led)
        leds <= bus.mem_wr_data[LED_WIDTH-1:0];
      if (fault_set)
        fault <= 1'b1;
      else if (fault_clr)
        fault <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && ena && we && is_ram)
      ram[ram_idx] <= bus.mem_wr_data;
  end

  assign bus.mem_rd_data = rd_q;
  assign bus_fault       = fault;
endmodule

// File: tb/tb_rv32i_mmio_memory.sv
// Directed, table-driven bench for rv32i_mmio_memory with hand-computed expectations.
// It also runs hand-written sequences for reset priority, enable freeze and the latched 64-bit counter read.
module tb_rv32i_mmio_memory;
  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [15:0] leds;
  logic        bus_fault;

  rv32i_mmio_memory_if bus ();

  rv32i_mmio_memory #(.RAM_WORDS(256), .INIT_FILE(""), .LED_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .bus       (bus.slave),
    .leds      (leds),
    .bus_fault (bus_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ena;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_fault;
    logic [15:0] exp_leds;
  } vec_t;

  vec_t vecs [27];
  int   nvec;
  int   n_chk;
  int   n_fail;

  localparam logic [31:0] A_LED   = 32'hF000_0000;
  localparam logic [31:0] A_LO    = 32'hF000_0004;
  localparam logic [31:0] A_HI    = 32'hF000_0008;
  localparam logic [31:0] A_FAULT = 32'hF000_000C;

  task automatic add(input logic e, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic c, input logic [31:0] r, input logic f, input logic [15:0] l);
    vecs[nvec] = '{e, w, a, d, c, r, f, l};
    nvec++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one access mid-cycle, let one rising edge pass, then settle just after that edge.
  task automatic step(input logic e, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ena             = e;
    bus.mem_wr_ena  = w;
    bus.mem_addr    = a;
    bus.mem_wr_data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    nvec   = 0;

    add(1, 1, 32'h10,     32'hDEAD_BEEF, 0, 32'h0,          0, 16'h0);
    add(1, 0, 32'h10,     32'h0,         1, 32'hDEAD_BEEF,  0, 16'h0);
    add(1, 1, 32'h20,     32'hAAAA_0000, 0, 32'h0,          0, 16'h0);
    add(1, 1, 32'h20,     32'h1234_5678, 1, 32'hAAAA_0000,  0, 16'h0);
    add(1, 0, 32'h20,     32'h0,         1, 32'h1234_5678,  0, 16'h0);
    add(1, 1, A_LED,      32'hFFFF_FFFF, 1, 32'h0,          0, 16'hFFFF);
    add(1, 0, A_LED,      32'h0,         1, 32'h0000_FFFF,  0, 16'hFFFF);
    add(1, 1, A_LED,      32'h0001_2345, 1, 32'h0000_FFFF,  0, 16'h2345);
    add(1, 0, 32'h12,     32'h0,         1, 32'hDEAD_BEEF,  1, 16'h2345);
    add(1, 0, 32'h8000_0000, 32'h0,      1, 32'h0,          1, 16'h2345);
    add(1, 1, A_FAULT,    32'h1,         1, 32'h1,          0, 16'h2345);
    add(1, 0, A_FAULT,    32'h0,         1, 32'h0,          0, 16'h2345);
    add(1, 0, 32'h8000_0000, 32'h0,      1, 32'h0,          1, 16'h2345);
    add(1, 1, 32'hF000_000D, 32'h1,      1, 32'h1,          1, 16'h2345);
    add(1, 1, A_FAULT,    32'h0,         1, 32'h1,          1, 16'h2345);
    add(1, 1, A_FAULT,    32'h1,         1, 32'h1,          0, 16'h2345);
    add(1, 0, 32'h400,    32'h0,         1, 32'h0,          1, 16'h2345);
    add(1, 1, A_FAULT,    32'h1,         1, 32'h1,          0, 16'h2345);
    add(1, 1, 32'h3FC,    32'h55AA_55AA, 0, 32'h0,          0, 16'h2345);
    add(1, 0, 32'h3FC,    32'h0,         1, 32'h55AA_55AA,  0, 16'h2345);
    add(1, 1, 32'h7FC,    32'h1,         1, 32'h0,          1, 16'h2345);
    add(1, 0, 32'h3FC,    32'h0,         1, 32'h55AA_55AA,  1, 16'h2345);
    add(1, 1, A_FAULT,    32'h1,         1, 32'h1,          0, 16'h2345);
    add(1, 1, A_HI,       32'h5,         1, 32'h0,          1, 16'h2345);
    add(1, 1, A_FAULT,    32'h1,         1, 32'h1,          0, 16'h2345);
    add(0, 1, A_LED,      32'h0,         1, 32'h1,          0, 16'h2345);
    add(1, 0, 32'h10,     32'h0,         1, 32'hDEAD_BEEF,  0, 16'h2345);

    rst             = 1'b1;
    ena             = 1'b0;
    bus.mem_wr_ena  = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset rd_data", bus.mem_rd_data, 32'h0);
    check("reset leds", {16'h0, leds}, 32'h0);
    check("reset fault", {31'h0, bus_fault}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < nvec; i++) begin
      step(vecs[i].ena, vecs[i].we, vecs[i].addr, vecs[i].wdat);
      if (vecs[i].chk_rd)
        check($sformatf("vec%0d rd_data", i), bus.mem_rd_data, vecs[i].exp_rd);
      check($sformatf("vec%0d fault", i), {31'h0, bus_fault}, {31'h0, vecs[i].exp_fault});
      check($sformatf("vec%0d leds", i), {16'h0, leds}, {16'h0, vecs[i].exp_leds});
    end

    // Reset must win over a coincident LED write, even with ena low.
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b1, A_LED, 32'hFFFF_FFFF);
    check("rst leds", {16'h0, leds}, 32'h0);
    check("rst rd_data", bus.mem_rd_data, 32'h0);
    check("rst fault", {31'h0, bus_fault}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // The counter is 0 after reset and advances only on enabled edges.
    step(1'b1, 1'b1, 32'h0, 32'h1111_1111);
    step(1'b1, 1'b0, A_LO, 32'h0);
    check("cycle lo after 1", bus.mem_rd_data, 32'h1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 32'h0, 32'hCAFE_F00D);
      check($sformatf("frozen rd_data %0d", i), bus.mem_rd_data, 32'h1);
    end
    step(1'b1, 1'b0, A_LO, 32'h0);
    check("cycle lo after freeze", bus.mem_rd_data, 32'h2);
    step(1'b1, 1'b0, 32'h0, 32'h0);
    check("ram0 after freeze", bus.mem_rd_data, 32'h1111_1111);

    // Preload the counter just below a low-word carry and check the latched high-word read.
    force dut.cycle_cnt = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.cycle_cnt;
    step(1'b1, 1'b0, A_LO, 32'h0);
    check("lo before carry", bus.mem_rd_data, 32'hFFFF_FFFF);
    step(1'b1, 1'b0, A_HI, 32'h0);
    check("hi latched", bus.mem_rd_data, 32'h0);
    step(1'b1, 1'b0, A_LO, 32'h0);
    check("lo after carry", bus.mem_rd_data, 32'h1);
    step(1'b1, 1'b0, A_HI, 32'h0);
    check("hi after carry", bus.mem_rd_data, 32'h1);
    check("fault clean", {31'h0, bus_fault}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
